// File: rtl/wb_test_unit_pkg.sv
// Shared types and constants for the Wishbone test peripheral.
// Command codes, register offsets and STATUS bit positions.
package test_unit_pkg;

    typedef enum logic [1:0] {
        TEST_PASS  = 2'd0,
        TEST_FAIL  = 2'd1,
        TEST_DONE  = 2'd2,
        TEST_CLEAR = 2'd3
    } test_code_e;

    // Register index = byte address bits [4:2]
    localparam logic [2:0] REG_CMD    = 3'd0;
    localparam logic [2:0] REG_SEL    = 3'd1;
    localparam logic [2:0] REG_PASS   = 3'd2;
    localparam logic [2:0] REG_FAIL   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    // STATUS layout
    localparam int ST_DONE     = 0;
    localparam int ST_TIMEOUT  = 1;
    localparam int ST_ANY_FAIL = 2;
    localparam int ST_BAD_CH   = 3;
    localparam int ST_ERR_LSB  = 16;

    // True when an 8-bit channel index names an existing channel
    function automatic logic chan_ok(input logic [7:0] ch, input int n);
        return {1'b0, ch} < 9'(n);
    endfunction

endpackage

// File: rtl/wb_test_unit_if.sv
// Wishbone classic bus bundle between firmware master and test unit.
// master drives cyc/stb/we/adr/dat_w; slave returns dat_r/ack.
interface wb_test_unit_if;

    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [4:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic        wb_ack;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w,
        input  wb_dat_r, wb_ack
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w,
        output wb_dat_r, wb_ack
    );

endinterface

// File: rtl/wb_test_unit_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Ports: clk, reset, clear, inc in; count out (WIDTH bits).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/wb_test_unit.sv
// Wishbone test peripheral: per-channel pass/fail counters, watchdog,
// and a registered test_stb/test_reg/test_channel command strobe.
// Ports: clk, reset (sync, active high); wb (slave bus);
//   test_stb/test_reg/test_channel command pulse; done, timeout
//   sticky flags; error_count saturating fail total.
module wb_test_unit
    import test_unit_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    wb_test_unit_if.slave          wb,
    output logic                   test_stb,
    output logic [1:0]             test_reg,
    output logic [7:0]             test_channel,
    output logic                   done,
    output logic                   timeout,
    output logic [COUNT_WIDTH-1:0] error_count
);

    // Read-back widths: counters clipped to 32, error_count to 16
    localparam int CW = (COUNT_WIDTH < 32) ? COUNT_WIDTH : 32;
    localparam int EW = (COUNT_WIDTH < 16) ? COUNT_WIDTH : 16;

    logic             acc;
    logic [2:0]       reg_idx;
    logic             cmd_wr;
    logic             sel_wr;
    test_code_e       code;
    logic [7:0]       cmd_ch;
    logic             ch_ok;
    logic             active;
    logic             is_pass;
    logic             is_fail;
    logic             is_done;
    logic             is_clear;
    logic             do_pass;
    logic             do_fail;
    logic             do_done;
    logic             do_clear;
    logic             do_bad;
    logic             fire;
    logic             wd_expire;
    logic             bad_channel;
    logic [7:0]       sel;
    logic [31:0]      rd_data;
    logic [COUNT_WIDTH-1:0] pass_sel;
    logic [COUNT_WIDTH-1:0] fail_sel;
    logic [COUNT_WIDTH-1:0] pass_cnt [NUM_CHANNELS];
    logic [COUNT_WIDTH-1:0] fail_cnt [NUM_CHANNELS];
    logic             unused;

    // A request is taken only while ack is low, so a held
    // request completes one transfer every second cycle.
    assign acc     = wb.wb_cyc & wb.wb_stb & ~wb.wb_ack;
    assign reg_idx = wb.wb_adr[4:2];
    assign cmd_wr  = acc & wb.wb_we & (reg_idx == REG_CMD);
    assign sel_wr  = acc & wb.wb_we & (reg_idx == REG_SEL);
    assign code    = test_code_e'(wb.wb_dat_w[1:0]);
    assign cmd_ch  = wb.wb_dat_w[15:8];
    assign ch_ok   = chan_ok(cmd_ch, NUM_CHANNELS);
    assign active  = ~done & ~timeout;

    assign unused = ^{wb.wb_dat_w[31:16], wb.wb_adr[1:0]};

    always_comb begin
        is_pass  = 1'b0;
        is_fail  = 1'b0;
        is_done  = 1'b0;
        is_clear = 1'b0;
        unique case (code)
            TEST_PASS:  is_pass  = 1'b1;
            TEST_FAIL:  is_fail  = 1'b1;
            TEST_DONE:  is_done  = 1'b1;
            TEST_CLEAR: is_clear = 1'b1;
        endcase
    end

    // Once finished, only CLEAR has any effect
    assign do_clear = cmd_wr & is_clear;
    assign do_pass  = cmd_wr & active & is_pass & ch_ok;
    assign do_fail  = cmd_wr & active & is_fail & ch_ok;
    assign do_done  = cmd_wr & active & is_done;
    assign do_bad   = cmd_wr & active & (is_pass | is_fail) & ~ch_ok;
    assign fire     = do_clear | (cmd_wr & active);

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        sat_counter #(.WIDTH(COUNT_WIDTH)) u_pass (
            .clk   (clk),
            .reset (reset),
            .clear (do_clear),
            .inc   (do_pass & (cmd_ch == 8'(i))),
            .count (pass_cnt[i])
        );
        sat_counter #(.WIDTH(COUNT_WIDTH)) u_fail (
            .clk   (clk),
            .reset (reset),
            .clear (do_clear),
            .inc   (do_fail & (cmd_ch == 8'(i))),
            .count (fail_cnt[i])
        );
    end

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_err (
        .clk   (clk),
        .reset (reset),
        .clear (do_clear),
        .inc   (do_fail),
        .count (error_count)
    );

    // Watchdog: expires on the cycle its count sits at LAST
    if (TIMEOUT_CYCLES > 0) begin : g_wd
        localparam int WD_W =
            (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
        localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT_CYCLES - 1);
        logic [WD_W-1:0] wd;

        always_ff @(posedge clk) begin
            if (reset || do_clear) begin
                wd <= '0;
            end else if (active && (wd != LAST)) begin
                wd <= wd + WD_W'(1);
            end
        end

        assign wd_expire = active & (wd == LAST);
    end else begin : g_no_wd
        assign wd_expire = 1'b0;
    end

    // Read mux; out-of-range SEL matches no channel and reads 0
    always_comb begin
        pass_sel = '0;
        fail_sel = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (sel == 8'(i)) begin
                pass_sel = pass_cnt[i];
                fail_sel = fail_cnt[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            REG_SEL:  rd_data[7:0] = sel;
            REG_PASS: rd_data[CW-1:0] = pass_sel[CW-1:0];
            REG_FAIL: rd_data[CW-1:0] = fail_sel[CW-1:0];
            REG_STATUS: begin
                rd_data[ST_DONE]     = done;
                rd_data[ST_TIMEOUT]  = timeout;
                rd_data[ST_ANY_FAIL] = (error_count != '0);
                rd_data[ST_BAD_CH]   = bad_channel;
                rd_data[ST_ERR_LSB +: EW] = error_count[EW-1:0];
            end
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb.wb_ack    <= 1'b0;
            wb.wb_dat_r  <= '0;
            test_stb     <= 1'b0;
            test_reg     <= '0;
            test_channel <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            bad_channel  <= 1'b0;
            sel          <= '0;
        end else begin
            wb.wb_ack <= acc;
            test_stb  <= fire;
            if (acc) begin
                wb.wb_dat_r <= wb.wb_we ? 32'd0 : rd_data;
            end
            if (fire) begin
                test_reg     <= wb.wb_dat_w[1:0];
                test_channel <= cmd_ch;
            end
            if (do_clear) begin
                done        <= 1'b0;
                timeout     <= 1'b0;
                bad_channel <= 1'b0;
                sel         <= '0;
            end else begin
                // DONE landing on the expiry cycle beats the watchdog
                if (do_done) begin
                    done <= 1'b1;
                end else if (wd_expire) begin
                    timeout <= 1'b1;
                end
                if (do_bad) begin
                    bad_channel <= 1'b1;
                end
                if (sel_wr) begin
                    sel <= wb.wb_dat_w[7:0];
                end
            end
        end
    end

endmodule

// File: doc/wb_test_unit.md
# wb_test_unit

Parametrised Wishbone test peripheral in the MCU, the successor to the single-register test interface. Firmware self-tests report pass/fail per test channel, signal completion, and read back results. The block keeps saturating per-channel counters, runs a completion watchdog, and drives a registered strobe/code pair that the simulation top samples to print results and end the run.

## Interface
- `NUM_CHANNELS`, 4: number of independent test channels (1..256).
- `COUNT_WIDTH`, 16: width of every pass/fail/total counter.
- `TIMEOUT_CYCLES`, 100000: watchdog limit in `clk` cycles; 0 disables the watchdog.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wb_cyc`, `wb_stb`, `wb_we`  in  1 each  Wishbone classic request.
- `wb_adr`  in  5  byte address; bits [4:2] select the register.
- `wb_dat_w`  in  32  write data.
- `wb_dat_r`  out  32  read data; valid while `wb_ack` is high.
- `wb_ack`  out  1  one-cycle acknowledge.
- `test_stb`  out  1  one-cycle pulse per accepted command.
- `test_reg`  out  2  command code, valid with `test_stb`.
- `test_channel`  out  8  channel index, valid with `test_stb`.
- `done`, `timeout`  out  1 each  sticky status flags.
- `error_count`  out  COUNT_WIDTH  saturating total of fail reports.

## Operation
- Registers: 0x00 CMD (W): [1:0] code, [15:8] channel. 0x04 SEL (R/W): read channel index. 0x08 PASS (R): pass count of SEL. 0x0C FAIL (R): fail count of SEL. 0x10 STATUS (R): [0] done, [1] timeout, [2] any_fail, [3] bad_channel, [31:16] `error_count` (zero-extended or truncated to 16 bits). Other offsets read 0 and ignore writes.
- Codes: PASS=0 increments pass[ch]. FAIL=1 increments fail[ch] and `error_count`. DONE=2 sets `done`. CLEAR=3 zeroes all counters, `done`, `timeout`, `bad_channel` and SEL, and restarts the watchdog.
- All counters saturate at 2^COUNT_WIDTH−1 and never wrap.
- Channel ≥ NUM_CHANNELS on PASS or FAIL: no counter changes and `bad_channel` sets (sticky). The `test_stb` pulse still fires.
- After `done` or `timeout`: PASS, FAIL and DONE are acked but ignored, with no `test_stb` pulse. CLEAR always works and always pulses.
- Watchdog: counter increments every cycle while neither `done` nor `timeout` is set. `timeout` sets on the cycle the count reaches TIMEOUT_CYCLES−1. If a DONE write lands in the same cycle, `done` wins and `timeout` stays 0.
- SEL ≥ NUM_CHANNELS: PASS and FAIL reads return 0.

## Timing
- Reset values: `wb_ack`=0, `wb_dat_r`=0, `test_stb`=0, `test_reg`=0, `test_channel`=0, `done`=0, `timeout`=0, `error_count`=0. All counters, SEL and the watchdog are 0.
- `wb_ack` asserts the cycle after `wb_cyc&wb_stb` is sampled while `wb_ack` is low. It is high for exactly one cycle.
- A held request therefore acks every second cycle; each ack is exactly one transfer.
- Write side effects, `test_stb`, `test_reg` and `test_channel` all update on the same edge that raises `wb_ack`.
- A read issued the cycle after a write's ack sees the updated value.
- Read data is registered and returned with `wb_ack`.
- `reset` mid-transfer drops `wb_ack` on the next edge; no side effect from the aborted request.

## Structure
- `test_unit_pkg`:
  - `test_code_e` enum (TEST_PASS, TEST_FAIL, TEST_DONE, TEST_CLEAR).
  - Register offset localparams.
  - STATUS bit positions.
- Sub-module `sat_counter` (params WIDTH; ports `clk`, `reset`, `clear`, `inc`, `count`). Instantiated 2×NUM_CHANNELS+1 times.
- The simulation top checks `test_stb`/`test_reg` directly.

## Test plan
- Reset, then write CMD 0x0000_0100 (PASS ch1) → `test_stb` pulse with `test_reg`=0 and `test_channel`=1. Write SEL=1, read PASS → 1; FAIL → 0.
- Three FAIL writes on ch2 (0x0000_0201) → FAIL(ch2)=3, `error_count`=3, STATUS[2]=1.
- COUNT_WIDTH=4: 17 PASS writes on ch0 → PASS reads 15 (saturated).
- PASS to ch 9 with NUM_CHANNELS=4 → all counters unchanged, STATUS[3]=1, `test_stb` pulses.
- TIMEOUT_CYCLES=50 with no writes → `timeout` rises 50 cycles after reset. A subsequent PASS → acked, no `test_stb`. CLEAR → `timeout`=0, pulse with `test_reg`=3.
- DONE write timed to land on the watchdog's final cycle → `done`=1, `timeout`=0. Later FAIL ignored, `error_count` unchanged.
